uart_rx: RTL
============

# uart_rx

Serial receiver for the UART link. It takes the asynchronous line from the pin, synchronizes it, and detects start bits with false-start rejection. It samples eight data bits LSB-first at mid-bit and checks the stop bit. Each good byte is presented with a one-cycle valid pulse. It pairs with `uart_tx` (8N1, same `CLKS_PER_BIT`) and feeds the byte-level logic above it.

## Interface
- `CLKS_PER_BIT`, 87: clock cycles per bit period. Legal range 4..255. Other values are out of contract.
- `i_Clock`  in  1  system clock; all logic is on its rising edge.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Rx_Serial`  in  1  raw serial line. It is asynchronous to `i_Clock` and idles high.
- `o_Rx_DV`  out  1  one-cycle pulse: `o_Rx_Byte` holds a newly received, correctly framed byte.
- `o_Rx_Byte`  out  8  last good byte. It holds its value until the next good byte.
- `o_Rx_Frame_Err`  out  1  one-cycle pulse: the stop bit was sampled low and the byte was discarded.
- `o_Rx_Active`  out  1  high from start-bit acceptance through the stop-bit sample.

## Operation
- Synchronizer: two flops, both reset to 1. All logic below uses only the synchronized line (`rx_s`).
- Let H = (CLKS_PER_BIT-1)/2, using integer division.
- Counter width: clog2(CLKS_PER_BIT). Bit index width: 3.
- Arming flag: set whenever `rx_s`=1 is sampled. Cleared on any start detection. Reset value 0.
- States:
  - IDLE: if armed and `rx_s`=0, clear count and go to START. Otherwise stay.
  - START: increment count until count==H. At that edge, if `rx_s`=0, set `o_Rx_Active`, clear count and go to DATA. If `rx_s`=1 (glitch), go to IDLE with no output pulse.
  - DATA: count 0..CLKS_PER_BIT-1. At count==CLKS_PER_BIT-1, shift `rx_s` into bit[index] and clear count. If index<7, increment index. At index==7, clear index and go to STOP.
  - STOP: at count==CLKS_PER_BIT-1, sample `rx_s` and clear `o_Rx_Active`.
    - Sample 1: load `o_Rx_Byte` from the shift register and pulse `o_Rx_DV`.
    - Sample 0: pulse `o_Rx_Frame_Err` and leave `o_Rx_Byte` unchanged.
    - Either way, go to CLEANUP.
  - CLEANUP: one cycle, then IDLE. Both pulses deassert here.
  - Unused encodings: go to IDLE.
- Break or stuck-low line after a frame error: the arming flag is clear, so no new frame starts until the line has been seen high.
- `o_Rx_DV` and `o_Rx_Frame_Err` are never high in the same cycle.

## Timing
- Reset values:
  - Outputs: `o_Rx_DV`=0, `o_Rx_Frame_Err`=0, `o_Rx_Active`=0, `o_Rx_Byte`=8'h00.
  - Internal: state=IDLE, count=0, index=0, synchronizer=2'b11, armed=0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). No pulse is produced. After release, the block behaves as from power-up, including re-arming.
- Let t0 be the first rising edge at which `i_Rx_Serial` is captured low.
  - START is entered at t0+2.
  - Bit n is sampled at edge t0+3+H+(n+1)·CLKS_PER_BIT.
  - The stop bit is sampled at t0+3+H+9·CLKS_PER_BIT. `o_Rx_DV` or `o_Rx_Frame_Err` is high for the one cycle after that edge.
  - With CLKS_PER_BIT=87 (H=43), the stop sample is at t0+829.
- Back-to-back frames: a new start bit whose falling edge arrives after the stop-bit sample is accepted. The block never needs a gap beyond the nominal stop bit.
- A low glitch shorter than H+1 cycles at `rx_s` is rejected.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding localparams (IDLE, START/DATA/STOP, CLEANUP), common with `uart_tx`;
  - the default `CLKS_PER_BIT`;
  - the data width constant (8).
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer with parameterized reset value (1 here), async active-high reset.
- Everything else is one FSM process plus a small output-register process in `uart_rx`.

## Test plan
- Reset, then send 8'hA5 from a `uart_tx` instance with CLKS_PER_BIT=87 -> `o_Rx_DV` is one cycle at t0+830 (stop sample at t0+829), `o_Rx_Byte`=8'hA5, `o_Rx_Frame_Err` stays 0.
- Send 8'h00, 8'hFF and 8'h3C back-to-back with no idle gap -> three `o_Rx_DV` pulses exactly 10·87 cycles apart, with the correct bytes.
- Drive a 20-cycle low glitch on an idle line -> no DV, no error, `o_Rx_Active` never 1, state back to IDLE within 45 cycles.
- Send a frame with the stop bit forced low, then hold the line low for 2000 cycles, then release -> one `o_Rx_Frame_Err` pulse, `o_Rx_Byte` unchanged, no further activity until the line goes high. A following frame with 8'h5A is received correctly.
- Assert `i_Reset` during data bit 4, release, then send 8'hC3 -> all outputs are 0 during reset, there is no pulse for the aborted frame, and 8'hC3 is received correctly.
- Rerun the 8'hA5 and back-to-back scenarios with CLKS_PER_BIT=4 -> bytes are correct and `o_Rx_DV` spacing is 40 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit blocks.
// Holds the frame state encoding, the default bit period and the data width.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 87;
  localparam int DATA_WIDTH           = 8;

  localparam logic [2:0] STATE_IDLE    = 3'd0;
  localparam logic [2:0] STATE_START   = 3'd1;
  localparam logic [2:0] STATE_DATA    = 3'd2;
  localparam logic [2:0] STATE_STOP    = 3'd3;
  localparam logic [2:0] STATE_CLEANUP = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = STATE_IDLE,
    ST_START   = STATE_START,
    ST_DATA    = STATE_DATA,
    ST_STOP    = STATE_STOP,
    ST_CLEANUP = STATE_CLEANUP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-in / byte-out bundle of the UART receiver.
// master is the receiver itself, slave is the line driver plus byte consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                  i_Rx_Serial;
  logic                  o_Rx_DV;
  logic [DATA_WIDTH-1:0] o_Rx_Byte;
  logic                  o_Rx_Frame_Err;
  logic                  o_Rx_Active;

  modport master (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Frame_Err,
    output o_Rx_Active
  );

  modport slave (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Frame_Err,
    input  o_Rx_Active
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// Both stages reset to RESET_VAL so an idle-high line looks idle out of reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_Async;
      r_sync <= r_meta;
    end
  end

  assign o_Sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, rejects short start glitches,
// samples data mid-bit LSB-first and reports either a good byte or a framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  uart_rx_if.master rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic                  w_rx_s;
  uart_state_e           r_state, w_state_next;
  logic [CNT_W-1:0]      r_count, w_count_next;
  logic [2:0]            r_index, w_index_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic                  r_armed, w_armed_next;
  logic                  r_active, w_active_next;
  logic                  w_dv_set;
  logic                  w_ferr_set;
  logic                  r_dv;
  logic                  r_ferr;
  logic [DATA_WIDTH-1:0] r_byte;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Async (rx_if.i_Rx_Serial),
    .o_Sync  (w_rx_s)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_index  <= '0;
      r_shift  <= '0;
      r_armed  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_index  <= w_index_next;
      r_shift  <= w_shift_next;
      r_armed  <= w_armed_next;
      r_active <= w_active_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_index_next  = r_index;
    w_shift_next  = r_shift;
    w_armed_next  = r_armed | w_rx_s;
    w_active_next = r_active;
    w_dv_set      = 1'b0;
    w_ferr_set    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A start is only believed once the line has been seen high since the last one.
        if (r_armed && !w_rx_s) begin
          w_state_next = ST_START;
          w_count_next = '0;
          w_armed_next = 1'b0;
        end
      end

      ST_START: begin
        if (r_count == HALF_CNT) begin
          w_count_next = '0;
          if (!w_rx_s) begin
            w_active_next = 1'b1;
            w_state_next  = ST_DATA;
          end else begin
            w_state_next  = ST_IDLE;
          end
        end else begin
          w_count_next = r_count + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (r_count == LAST_CNT) begin
          w_count_next          = '0;
          w_shift_next[r_index] = w_rx_s;
          if (r_index == 3'd7) begin
            w_index_next = '0;
            w_state_next = ST_STOP;
          end else begin
            w_index_next = r_index + 3'd1;
          end
        end else begin
          w_count_next = r_count + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (r_count == LAST_CNT) begin
          w_count_next  = '0;
          w_active_next = 1'b0;
          w_state_next  = ST_CLEANUP;
          if (w_rx_s) begin
            w_dv_set = 1'b1;
          end else begin
            // A low stop bit is usually a break; wait for the line to return high.
            w_ferr_set   = 1'b1;
            w_armed_next = 1'b0;
          end
        end else begin
          w_count_next = r_count + CNT_W'(1);
        end
      end

      ST_CLEANUP: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next  = ST_IDLE;
        w_count_next  = '0;
        w_index_next  = '0;
        w_active_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_dv   <= 1'b0;
      r_ferr <= 1'b0;
      r_byte <= '0;
    end else begin
      r_dv   <= w_dv_set;
      r_ferr <= w_ferr_set;
      if (w_dv_set) begin
        r_byte <= r_shift;
      end
    end
  end

  assign rx_if.o_Rx_DV        = r_dv;
  assign rx_if.o_Rx_Frame_Err = r_ferr;
  assign rx_if.o_Rx_Byte      = r_byte;
  assign rx_if.o_Rx_Active    = r_active;

endmodule
